// File: rtl/tick_pkg.sv
// Shared constants, write-stage record and divisor helper for the tick divider bank.
package tick_pkg;

  localparam int unsigned CLK_HZ   = 100_000_000;
  localparam int          DIV_W    = 27;
  localparam int          CH_W_MAX = 4;

  // The stage record is sized for the largest bank (16 channels) and the default divisor width.
  typedef struct packed {
    logic [CH_W_MAX-1:0] ch;
    logic [DIV_W-1:0]    div;
  } wr_stage_t;

  function automatic int unsigned hz_to_div(input int unsigned clk_hz, input int unsigned hz);
    return (hz == 0) ? 0 : clk_hz / hz;
  endfunction

endpackage

// File: rtl/tick_divider_bank_if.sv
// Divisor write port of the tick divider bank: valid/ready request plus error pulse.
interface tick_divider_bank_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 27
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, output cfg_ready, cfg_err);

endinterface

// File: rtl/tick_channel.sv
// One programmable tick generator: counter, shadow divisor with pending bit, tick flop.
// Optional square-wave output when TICK_SQUARE_EN is defined.
module tick_channel #(
  parameter int          DIV_W   = 27,
  parameter int unsigned DEF_DIV = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             live,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             tick,
  output logic             pending
`ifdef TICK_SQUARE_EN
  ,
  output logic             sq
`endif
);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] sdiv;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last;
  logic             tc;
  logic             run;
  logic             hit;

  // A divisor of 0 behaves as 1; >= keeps a shrunk divisor from wrapping past the end.
  assign last = (div == '0) ? '0 : div - DIV_W'(1);
  assign tc   = cnt >= last;
  assign run  = live && !sync && en;
  assign hit  = run && tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      div     <= DIV_W'(DEF_DIV);
      sdiv    <= '0;
      pending <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= hit;
      if (!run || tc) cnt <= '0;
      else            cnt <= cnt + DIV_W'(1);
      // Shadow lands at the terminal count, or at once while the channel is idle; sync defers it.
      if (pending && live && !sync && (!en || tc)) begin
        div     <= sdiv;
        pending <= 1'b0;
      end
      if (wr) begin
        sdiv    <= wr_div;
        pending <= 1'b1;
      end
    end
  end

`ifdef TICK_SQUARE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   sq <= 1'b0;
    else if (sync) sq <= 1'b0;
    else if (hit)  sq <= ~sq;
  end
`endif

endmodule

// File: rtl/tick_divider_bank.sv
// Bank of NUM_CH programmable tick generators with a staged divisor write port.
// Define TICK_SQUARE_EN to add the per-channel 50% square output sq.
module tick_divider_bank #(
  parameter int unsigned CLK_HZ  = tick_pkg::CLK_HZ,
  parameter int          NUM_CH  = 4,
  parameter int          DIV_W   = tick_pkg::DIV_W,
  parameter int unsigned DEF_DIV = tick_pkg::hz_to_div(CLK_HZ, 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  tick_divider_bank_if.slave cfg,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] tick
`ifdef TICK_SQUARE_EN
  ,
  output logic [NUM_CH-1:0] sq
`endif
);
  import tick_pkg::*;

  logic        live;
  logic        ready_q;
  logic        err_q;
  logic        stg_valid;
  wr_stage_t   stg;
  logic        accept;
  logic [NUM_CH-1:0] wr_vec;

  assign accept        = cfg.cfg_valid && ready_q;
  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;

  // live holds every channel for the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live      <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      stg_valid <= 1'b0;
      stg       <= '0;
    end else begin
      live      <= 1'b1;
      ready_q   <= !accept;
      stg_valid <= accept;
      if (accept) begin
        stg.ch  <= CH_W_MAX'(cfg.cfg_ch);
        stg.div <= tick_pkg::DIV_W'(cfg.cfg_div);
      end
      err_q <= stg_valid && (int'(stg.ch) >= NUM_CH);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_vec[i] = stg_valid && (stg.ch == CH_W_MAX'(i));

    tick_channel #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .live    (live),
      .en      (ch_en[i]),
      .sync    (sync),
      .wr      (wr_vec[i]),
      .wr_div  (DIV_W'(stg.div)),
      .tick    (tick[i]),
      .pending (pending[i])
`ifdef TICK_SQUARE_EN
      ,
      .sq      (sq[i])
`endif
    );
  end

endmodule

// File: tb/tb_tick_divider_bank.sv
// Scoreboard bench for tick_divider_bank: bank A (4 ch) runs the main schedule, bank B (5 ch) the error path.
module tb_tick_divider_bank;

  localparam int NA = 4;
  localparam int NB = 5;
  localparam int DW = 27;

  localparam int K_TICK_A = 0, K_PEND_A = 1, K_RDY_A = 2, K_ERR_A = 3;
  localparam int K_TICK_B = 4, K_PEND_B = 5, K_RDY_B = 6, K_ERR_B = 7;
  localparam int K_SQ_A   = 8, K_SQ_B   = 9;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sync_a;
  logic [NA-1:0] ch_en_a, tick_a, pend_a;
  logic [NB-1:0] ch_en_b, tick_b, pend_b;
`ifdef TICK_SQUARE_EN
  logic [NA-1:0] sq_a;
  logic [NB-1:0] sq_b;
`endif
  logic [NA-1:0] sq_exp_a;
  logic [NB-1:0] sq_exp_b;

  int   cyc;
  int   phase;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  tick_divider_bank_if #(.NUM_CH(NA), .DIV_W(DW)) bus_a ();
  tick_divider_bank_if #(.NUM_CH(NB), .DIV_W(DW)) bus_b ();

  tick_divider_bank #(.CLK_HZ(100_000_000), .NUM_CH(NA), .DIV_W(DW), .DEF_DIV(10)) dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .ch_en   (ch_en_a),
    .sync    (sync_a),
    .cfg     (bus_a),
    .pending (pend_a),
    .tick    (tick_a)
`ifdef TICK_SQUARE_EN
    ,
    .sq      (sq_a)
`endif
  );

  tick_divider_bank #(.CLK_HZ(100_000_000), .NUM_CH(NB), .DIV_W(DW), .DEF_DIV(10)) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .ch_en   (ch_en_b),
    .sync    (1'b0),
    .cfg     (bus_b),
    .pending (pend_b),
    .tick    (tick_b)
`ifdef TICK_SQUARE_EN
    ,
    .sq      (sq_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d phase %0d: got %0h expected %0h", tag, cyc, phase, obs, exp);
    end
  endtask

  // Expected behaviour of bank A, derived cycle by cycle from the stimulus schedule below.
  function automatic logic [NA-1:0] exp_tick_a(input int c);
    logic [NA-1:0] t;
    if (phase == 1) return (c == 11 || c == 21) ? '1 : '0;
    t[0] = c inside {11, 21, 31, 41, 51, 68, 78, 88};
    t[1] = c inside {11, 21, 31, 41, 44, 47, 50, 53, 56, 61, 71, 81, 91};
    t[2] = (c inside {11, 21, 31, 41, 51}) || (c >= 68);
    t[3] = c inside {11, 21, 31, 41, 51, 68, 85, 95};
    return t;
  endfunction

  function automatic logic [NA-1:0] exp_pend_a(input int c);
    logic [NA-1:0] p;
    if (phase == 1) return '0;
    p[0] = (c >= 58 && c < 68);
    p[1] = (c >= 35 && c < 41) || (c >= 56 && c < 61);
    p[2] = (c >= 54 && c < 68);
    p[3] = 1'b0;
    return p;
  endfunction

  function automatic logic exp_rdy_a(input int c);
    if (phase == 1) return 1'b1;
    return !(c inside {34, 53, 55, 57});
  endfunction

  function automatic logic [NB-1:0] exp_tick_b(input int c);
    logic [NB-1:0] t;
    if (phase == 1) return (c == 11 || c == 21) ? '1 : '0;
    t[3:0] = (c >= 20 && (c - 20) % 10 == 0) ? 4'hF : 4'h0;
    t[4]   = (c >= 13 && (c - 13) % 3 == 0);
    return t;
  endfunction

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_TICK_A: return 32'(tick_a);
      K_PEND_A: return 32'(pend_a);
      K_RDY_A:  return 32'(bus_a.cfg_ready);
      K_ERR_A:  return 32'(bus_a.cfg_err);
      K_TICK_B: return 32'(tick_b);
      K_PEND_B: return 32'(pend_b);
      K_RDY_B:  return 32'(bus_b.cfg_ready);
      K_ERR_B:  return 32'(bus_b.cfg_err);
`ifdef TICK_SQUARE_EN
      K_SQ_A:   return 32'(sq_a);
      K_SQ_B:   return 32'(sq_b);
`endif
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string tag_of(input int kind);
    case (kind)
      K_TICK_A: return "tick_a";
      K_PEND_A: return "pending_a";
      K_RDY_A:  return "cfg_ready_a";
      K_ERR_A:  return "cfg_err_a";
      K_TICK_B: return "tick_b";
      K_PEND_B: return "pending_b";
      K_RDY_B:  return "cfg_ready_b";
      K_ERR_B:  return "cfg_err_b";
      K_SQ_A:   return "sq_a";
      K_SQ_B:   return "sq_b";
      default:  return "unknown";
    endcase
  endfunction

  task automatic push(input int kind, input logic [31:0] exp);
    sb.push_back('{cyc, kind, exp});
  endtask

  task automatic push_cycle(input int c);
    push(K_TICK_A, 32'(exp_tick_a(c)));
    push(K_PEND_A, 32'(exp_pend_a(c)));
    push(K_RDY_A,  32'(exp_rdy_a(c)));
    push(K_ERR_A,  32'd0);
    push(K_TICK_B, 32'(exp_tick_b(c)));
    push(K_PEND_B, (phase == 0 && c == 7) ? 32'h10 : 32'h0);
    push(K_RDY_B,  (phase == 0 && (c == 4 || c == 6)) ? 32'd0 : 32'd1);
    push(K_ERR_B,  (phase == 0 && c == 5) ? 32'd1 : 32'd0);
    if (phase == 0 && c == 58) sq_exp_a = '0;
    sq_exp_a ^= exp_tick_a(c);
    sq_exp_b ^= exp_tick_b(c);
`ifdef TICK_SQUARE_EN
    push(K_SQ_A, 32'(sq_exp_a));
    push(K_SQ_B, 32'(sq_exp_b));
`endif
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check_val(tag_of(sb[i].kind), observe(sb[i].kind), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic step(input bit do_push);
    @(posedge clk);
    cyc++;
    #1;
    if (do_push) push_cycle(cyc);
  endtask

  task automatic drive(input int c);
    case (c)
      3:  begin bus_b.cfg_valid = 1'b1; bus_b.cfg_ch = 3'd5; bus_b.cfg_div = 27'd3; end
      4:  bus_b.cfg_ch = 3'd4;
      6:  bus_b.cfg_valid = 1'b0;
      10: ch_en_b = '1;
      33: begin bus_a.cfg_valid = 1'b1; bus_a.cfg_ch = 2'd1; bus_a.cfg_div = 27'd3; end
      34: bus_a.cfg_valid = 1'b0;
      52: begin bus_a.cfg_valid = 1'b1; bus_a.cfg_ch = 2'd2; bus_a.cfg_div = 27'd0; end
      53: begin bus_a.cfg_ch = 2'd1; bus_a.cfg_div = 27'd10; end
      55: begin bus_a.cfg_ch = 2'd0; bus_a.cfg_div = 27'd10; end
      57: begin bus_a.cfg_valid = 1'b0; sync_a = 1'b1; end
      58: sync_a = 1'b0;
      70: ch_en_a[3] = 1'b0;
      75: ch_en_a[3] = 1'b1;
      default: ;
    endcase
  endtask

  task automatic reset_checks(input string tag);
    check_val({tag, "_tick_a"},  32'(tick_a), 32'd0);
    check_val({tag, "_pend_a"},  32'(pend_a), 32'd0);
    check_val({tag, "_rdy_a"},   32'(bus_a.cfg_ready), 32'd0);
    check_val({tag, "_err_a"},   32'(bus_a.cfg_err), 32'd0);
    check_val({tag, "_tick_b"},  32'(tick_b), 32'd0);
    check_val({tag, "_pend_b"},  32'(pend_b), 32'd0);
`ifdef TICK_SQUARE_EN
    check_val({tag, "_sq_a"},    32'(sq_a), 32'd0);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    phase    = 0;
    sq_exp_a = '0;
    sq_exp_b = '0;
    rst_n    = 1'b0;
    sync_a   = 1'b0;
    ch_en_a  = '1;
    ch_en_b  = '0;
    bus_a.cfg_valid = 1'b0; bus_a.cfg_ch = '0; bus_a.cfg_div = '0;
    bus_b.cfg_valid = 1'b0; bus_b.cfg_ch = '0; bus_b.cfg_div = '0;

    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");

    @(negedge clk);
    rst_n = 1'b1;
    while (cyc < 96) begin
      step(1'b1);
      drive(cyc);
    end

    // A write accepted one cycle before reset must be lost.
    step(1'b0);
    bus_a.cfg_valid = 1'b1; bus_a.cfg_ch = 2'd0; bus_a.cfg_div = 27'd5;
    step(1'b0);
    check_val("midrst_accepted", 32'(bus_a.cfg_ready), 32'd0);
    rst_n = 1'b0;
    bus_a.cfg_valid = 1'b0;
    @(negedge clk);
    reset_checks("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    cyc      = 0;
    phase    = 1;
    sq_exp_a = '0;
    sq_exp_b = '0;
    while (cyc < 22) step(1'b1);

    @(negedge clk);
    #1;
    check_val("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
